// File: rtl/hci_mem_l2_responder.sv
// HCI L2 bank responder: grants requests, drives a fixed-latency word SRAM, returns in-order responses.
// Partial byte-enable writes use read-modify-write. Optional counters: define HCI_L2_RESP_PERF_EN.
module hci_mem_l2_responder #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned BW       = 8,
    parameter int unsigned IW       = 20,
    parameter int unsigned SRAM_LAT = 1,
    parameter int unsigned SAW      = AW - $clog2(DW/8)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 req_i,
    input  logic [AW-1:0]        add_i,
    input  logic                 wen_i,
    input  logic [DW-1:0]        data_i,
    input  logic [DW/BW-1:0]     be_i,
    input  logic [IW-1:0]        id_i,
    output logic                 gnt_o,
    output logic                 r_valid_o,
    output logic [DW-1:0]        r_data_o,
    output logic [IW-1:0]        r_id_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [SAW-1:0]       sram_addr_o,
    output logic [DW-1:0]        sram_wdata_o,
    input  logic [DW-1:0]        sram_rdata_i,
    output logic [31:0]          perf_rd_o,
    output logic [31:0]          perf_wr_o,
    output logic [31:0]          perf_stall_o
);

    localparam int unsigned NB  = DW / BW;
    localparam int unsigned OFS = $clog2(DW/8);
    localparam int unsigned CW  = $clog2(SRAM_LAT + 1);

    typedef enum logic {
        IDLE,
        RMW_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SAW-1:0]    hold_addr_q, hold_addr_d;
    logic [DW-1:0]     hold_data_q, hold_data_d;
    logic [NB-1:0]     hold_be_q, hold_be_d;
    logic [SAW-1:0]    req_addr;
    logic [DW-1:0]     merged;
    logic              grant;

    logic              pipe_vld_q [SRAM_LAT];
    logic [IW-1:0]     pipe_id_q  [SRAM_LAT];
    logic              pipe_rd_q  [SRAM_LAT];

    assign req_addr = add_i[AW-1:AW-SAW];
    assign grant    = req_i & gnt_o;

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            merged[i*BW +: BW] = hold_be_q[i] ? hold_data_q[i*BW +: BW] : sram_rdata_i[i*BW +: BW];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        hold_be_d    = hold_be_q;
        gnt_o        = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        // Reset is folded in so that grant and SRAM strobes stay low while rst_i is held.
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    gnt_o = 1'b1;
                    if (req_i) begin
                        if (wen_i) begin
                            sram_req_o  = 1'b1;
                            sram_addr_o = req_addr;
                        end else if (&be_i) begin
                            sram_req_o   = 1'b1;
                            sram_we_o    = 1'b1;
                            sram_addr_o  = req_addr;
                            sram_wdata_o = data_i;
                        end else if (|be_i) begin
                            sram_req_o  = 1'b1;
                            sram_addr_o = req_addr;
                            hold_addr_d = req_addr;
                            hold_data_d = data_i;
                            hold_be_d   = be_i;
                            cnt_d       = CW'(SRAM_LAT);
                            state_d     = RMW_WAIT;
                        end
                    end
                end
                RMW_WAIT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        sram_req_o   = 1'b1;
                        sram_we_o    = 1'b1;
                        sram_addr_o  = hold_addr_q;
                        sram_wdata_o = merged;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_be_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_be_q   <= hold_be_d;
        end
    end

    // Response delay line runs independently of the FSM, so it keeps shifting during RMW_WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SRAM_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_id_q[i]  <= '0;
                pipe_rd_q[i]  <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= grant;
            pipe_id_q[0]  <= grant ? id_i : '0;
            pipe_rd_q[0]  <= grant & wen_i;
            for (int unsigned i = 1; i < SRAM_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
                pipe_rd_q[i]  <= pipe_rd_q[i-1];
            end
        end
    end

    assign r_valid_o = pipe_vld_q[SRAM_LAT-1];
    assign r_id_o    = pipe_id_q[SRAM_LAT-1];
    assign r_data_o  = (pipe_vld_q[SRAM_LAT-1] && pipe_rd_q[SRAM_LAT-1]) ? sram_rdata_i : '0;

`ifdef HCI_L2_RESP_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^add_i[OFS-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else if (clear_i) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (grant && wen_i && !(&perf_rd_q)) begin
                perf_rd_q <= perf_rd_q + 32'd1;
            end
            if (grant && !wen_i && !(&perf_wr_q)) begin
                perf_wr_q <= perf_wr_q + 32'd1;
            end
            if (state_q == RMW_WAIT && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_rd_o    = perf_rd_q;
    assign perf_wr_o    = perf_wr_q;
    assign perf_stall_o = perf_stall_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{clear_i, add_i[OFS-1:0]};
    assign perf_rd_o     = '0;
    assign perf_wr_o     = '0;
    assign perf_stall_o  = '0;
`endif

endmodule

// File: doc/hci_mem_l2_responder.md
Name: hci_mem_l2_responder

Overview:
- Memory-side responder for the HCI L2 memory interface: it terminates one bank port driven by the L2 log interconnect.
- Accepts req/add/wen/data/be/id, grants, and drives a single-port word-write SRAM macro with fixed read latency.
- Returns r_valid/r_data/r_id in order, exactly one response per granted transaction.
- Performs read-modify-write for partial byte-enable writes, because the macro has no byte mask.

Parameters:
AW, 32, byte address width of add_i
DW, 32, data width
BW, 8, bits per byte-enable lane
IW, 20, transaction ID width
SRAM_LAT, 1, SRAM read latency in cycles; legal range 1..4
SAW, AW-$clog2(DW/8), SRAM word address width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear of performance counters
req_i  in  1  request valid
add_i  in  AW  byte address
wen_i  in  1  1=read, 0=write
data_i  in  DW  write data
be_i  in  DW/BW  byte enables
id_i  in  IW  transaction ID
gnt_o  out  1  grant
r_valid_o  out  1  response valid
r_data_o  out  DW  read data
r_id_o  out  IW  response ID
sram_req_o  out  1  SRAM access
sram_we_o  out  1  1=write
sram_addr_o  out  SAW  word address, add_i[AW-1:AW-SAW]
sram_wdata_o  out  DW  SRAM write data
sram_rdata_i  in  DW  SRAM read data, valid SRAM_LAT cycles after a read access
perf_rd_o  out  32  read count
perf_wr_o  out  32  write count
perf_stall_o  out  32  RMW stall cycles

Behaviour:
- Reset (rst_i high, async): FSM to IDLE, response pipeline cleared, counters 0. gnt_o=0, r_valid_o=0, sram_req_o=0 while rst_i is high. r_data_o=0, r_id_o=0.
- FSM states: IDLE, RMW_WAIT.
- IDLE: gnt_o=1. A transaction is granted in cycle T when req_i & gnt_o.
- Read in IDLE: sram_req_o=1, sram_we_o=0 in cycle T (combinational).
- Full write in IDLE (be all ones): sram_req_o=1, sram_we_o=1, sram_wdata_o=data_i in cycle T.
- Null write in IDLE (be==0): granted, no SRAM access.
- Partial write in IDLE (be neither 0 nor all ones): issue SRAM read at T. Capture add, data, be into holding registers. Go to RMW_WAIT with latency counter=SRAM_LAT.
- RMW_WAIT: gnt_o=0 and no new SRAM access until the merge cycle. Counter decrements each cycle. In cycle T+SRAM_LAT: merged word = per lane be ? held data : sram_rdata_i. SRAM write issued that cycle (sram_we_o=1). Return to IDLE; gnt_o=1 again at T+SRAM_LAT+1.
- Response pipeline: SRAM_LAT-deep shift register of {valid, id, is_read}, loaded at each grant. It keeps shifting during RMW_WAIT.
- Every granted transaction gets r_valid_o=1 in exactly cycle T+SRAM_LAT, with r_id_o = its id.
- r_data_o = sram_rdata_i for reads and 0 for writes of any kind, including partial writes.
- Responses are strictly in grant order. Back-to-back reads sustain 1 transaction/cycle.
- Requests pending while gnt_o=0 must be held by the initiator (HCI rule). The block does not sample them.
- Read after write to the same word: the later read returns the new data (SRAM write-first ordering by issue cycle).
- rst_i mid-RMW: held write discarded, no SRAM write, in-flight responses dropped.
- sram_wdata_o=0 and sram_addr_o=0 when sram_req_o=0.

Optional Feature:
HCI_L2_RESP_PERF_EN
- Defined:
  - perf_rd_o increments per granted read.
  - perf_wr_o increments per granted write, including null and partial writes.
  - perf_stall_o increments per cycle in RMW_WAIT.
  - All counters are 32-bit saturating at 0xFFFFFFFF. clear_i zeroes them next edge; clear wins over increment.
- Undefined: counters not built, perf_* tied to 0, clear_i ignored.

Test Plan:
- SRAM_LAT=2. Write 0xDEADBEEF (be=4'hF, id=5) to 0x40, then read 0x40 (id=9) -> write response r_valid at T+2, id 5, data 0. Read response id 9, data 0xDEADBEEF. sram_req_o asserted once per transaction.
- Word 0x40 holds 0xDEADBEEF. Partial write data 0x000000AA, be=4'h1 -> gnt_o low 2 cycles, then SRAM write 0xDEADBEAA. Next read returns 0xDEADBEAA.
- 8 back-to-back reads, ids 0..7 -> gnt_o stays 1, r_valid high 8 consecutive cycles from T+SRAM_LAT, ids 0..7 in order.
- Write with be=0, id=3 -> granted, no sram_req_o, r_valid at T+SRAM_LAT with id 3, data 0.
- rst_i pulsed during RMW_WAIT -> no SRAM write issued, r_valid_o=0, gnt_o=1 after release, word contents unchanged.
- PERF_EN defined: 3 reads, 1 partial write, SRAM_LAT=2 -> perf_rd=3, perf_wr=1, perf_stall=2. clear_i -> all 0 next cycle.
